// File: rtl/rom_reader.sv
// rom_reader -- burst fetch engine in front of a synchronous ROM (one-cycle
// read latency). A start pulse reads `length` consecutive words from
// `base_addr`. Each word is truncated to DATA_WIDTH bits and delivered in
// order on a valid/ready stream. A 4-entry FIFO lets the stream run at full
// rate under backpressure.
//
// Build option: define ROM_READER_WRAP_EN so that addresses wrap modulo DEPTH.
// Without it, a request that runs past the end of the ROM is rejected and
// `err` pulses together with `done`.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               request pulse, sampled only when idle
//   base_addr, length   request parameters; length is clamped to DEPTH
//   busy, done, err     transfer status; done and err are single-cycle pulses
//   start_rom, rom_addr registered ROM read enable and address
//   rom_data            ROM output; only the low DATA_WIDTH bits are used
//   out_data, out_valid, out_ready   output stream (head of the FIFO)
module rom_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int LEN_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  start_rom,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [31:0]           rom_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remain_q;
  logic                  pend_q;
  logic                  start_rom_q;
  logic [ADDR_WIDTH-1:0] rom_addr_q;
  logic                  busy_q, done_q, err_q, rej_q;

  logic [DATA_WIDTH-1:0] mem_q [4];
  logic [1:0]            wr_q, rd_q;
  logic [2:0]            cnt_q, cnt_d;

  logic [LEN_WIDTH-1:0]  len_clamp;
  logic                  req_bad;
  logic                  push, pop, credit_ok, drained;

  // Upper ROM bits are intentionally dropped.
  logic unused_rom_bits;
  assign unused_rom_bits = ^rom_data[31:DATA_WIDTH];

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_WIDTH'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  assign len_clamp = (length > LEN_WIDTH'(DEPTH)) ? LEN_WIDTH'(DEPTH) : length;

`ifdef ROM_READER_WRAP_EN
  assign req_bad = 1'b0;
`else
  assign req_bad = (32'(base_addr) + 32'(len_clamp)) > 32'(DEPTH);
`endif

  assign push = pend_q;
  assign pop  = (cnt_q != 3'd0) && out_ready;

  // Credit covers words already queued, the read in flight at the ROM and the
  // word arriving this cycle, so the FIFO can never overflow.
  assign credit_ok = (cnt_q + {2'b00, start_rom_q} + {2'b00, pend_q}) < 3'd4;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 3'd1;
    else if (!push && pop) cnt_d = cnt_q - 3'd1;
  end

  // Leaving DRAIN looks at the post-edge FIFO count so that done follows the
  // last accept by exactly one cycle.
  assign drained = !pend_q && !start_rom_q && (cnt_d == 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      pend_q      <= 1'b0;
      start_rom_q <= 1'b0;
      rom_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rej_q       <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      for (int unsigned i = 0; i < 4; i++) mem_q[i] <= '0;
    end else begin
      pend_q      <= start_rom_q;
      start_rom_q <= 1'b0;

      if (push) begin
        mem_q[wr_q] <= rom_data[DATA_WIDTH-1:0];
        wr_q        <= wr_q + 2'd1;
      end
      if (pop) rd_q <= rd_q + 2'd1;
      cnt_q <= cnt_d;

      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            rej_q  <= req_bad;
            if (req_bad || (len_clamp == '0)) begin
              state_q <= FIN;
            end else begin
              // First read goes out on the accepting edge itself.
              start_rom_q <= 1'b1;
              rom_addr_q  <= base_addr;
              addr_q      <= next_addr(base_addr);
              remain_q    <= len_clamp - LEN_WIDTH'(1);
              state_q     <= (len_clamp == LEN_WIDTH'(1)) ? DRAIN : FETCH;
            end
          end
        end
        FETCH: begin
          if (credit_ok) begin
            start_rom_q <= 1'b1;
            rom_addr_q  <= addr_q;
            addr_q      <= next_addr(addr_q);
            remain_q    <= remain_q - LEN_WIDTH'(1);
            if (remain_q == LEN_WIDTH'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (drained) begin
            state_q <= FIN;
            done_q  <= 1'b1;
            err_q   <= rej_q;
            busy_q  <= 1'b0;
          end
        end
        FIN: begin
          // Entered from IDLE with done low (no-read requests) or from DRAIN
          // with done already raised; either way done pulses exactly once.
          if (done_q) begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            state_q <= IDLE;
          end else begin
            done_q <= 1'b1;
            err_q  <= rej_q;
            busy_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign start_rom = start_rom_q;
  assign rom_addr  = rom_addr_q;
  assign out_data  = mem_q[rd_q];
  assign out_valid = (cnt_q != 3'd0);

endmodule

// File: tb/tb_rom_reader.sv
// Self-checking bench for rom_reader with a behavioural ROM (mem[a] = a+1,
// upper bits filled with junk to exercise truncation). Expected words are
// queued when a request is driven and compared as the stream accepts them.
module tb_rom_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] base_addr = '0;
  logic [3:0] length = '0;
  logic       busy, done, err, start_rom;
  logic [2:0] rom_addr;
  logic [31:0] rom_data = '0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;

  rom_reader #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .err(err), .start_rom(start_rom), .rom_addr(rom_addr),
    .rom_data(rom_data), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (start_rom) rom_data <= {24'hC3C3C3, 8'(rom_addr) + 8'd1};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  logic [7:0] exp_q[$];

  // Stream monitor: scoreboard pops, stall stability, outstanding-read bound.
  int         issued = 0, accepted = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      issued = 0; accepted = 0; prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("stall_valid", int'(out_valid), 1);
        check_eq("stall_data", int'(out_data), int'(prev_data));
      end
      if (start_rom) issued++;
      if (out_valid && out_ready) begin
        accepted++;
        if (exp_q.size() == 0) check_eq("unexpected_word", int'(out_data), -1);
        else check_eq("word", int'(out_data), int'(exp_q.pop_front()));
      end
      check_eq("outstanding_le4", int'((issued - accepted) <= 4), 1);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  int s_cyc, exp_sr, exp_rej;
  int first_v, last_acc, done_c, sr_cnt, err_d;

  task automatic drive_start(input int b, input int l);
    int lc;
    bit acc;
    lc = (l > 8) ? 8 : l;
`ifdef ROM_READER_WRAP_EN
    acc = 1'b1;
`else
    acc = (b + lc) <= 8;
`endif
    exp_sr  = acc ? lc : 0;
    exp_rej = acc ? 0 : 1;
    for (int i = 0; i < exp_sr; i++) exp_q.push_back(8'(((b + i) % 8) + 1));
    @(posedge clk); #1;
    start = 1'b1; base_addr = 3'(b); length = 4'(l);
    @(posedge clk); #1;
    start = 1'b0;
    s_cyc = cyc;
  endtask

  // Runs from the cycle after the accepting edge until done (bounded).
  task automatic observe(input logic [3:0] rpat, input bit poke);
    first_v = -1; last_acc = -1; done_c = -1; sr_cnt = 0; err_d = 0;
    for (int n = 0; n < 200; n++) begin
      if (poke) start = (n == 0);
      if (n == 0) check_eq("busy_after_start", int'(busy), 1);
      if (start_rom) sr_cnt++;
      if (out_valid && first_v < 0) first_v = cyc;
      if (done) begin
        done_c = cyc; err_d = int'(err);
        break;
      end
      out_ready = rpat[n % 4];
      if (out_valid && out_ready) last_acc = cyc;
      @(posedge clk); #1;
    end
    if (done_c < 0) check_eq("done_timeout", 0, 1);
  endtask

  task automatic post_checks(input bit full_rate);
    check_eq("start_rom_cycles", sr_cnt, exp_sr);
    check_eq("err_at_done", err_d, exp_rej);
    if (exp_sr == 0) begin
      check_eq("no_out_valid", int'(first_v < 0), 1);
      check_eq("done_latency", done_c - s_cyc, 1);
    end else begin
      check_eq("first_word_latency", first_v - s_cyc, 2);
      check_eq("done_after_last_accept", done_c - last_acc, 1);
      if (full_rate) check_eq("burst_span", last_acc - first_v, exp_sr - 1);
    end
    check_eq("scoreboard_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    check_eq("done_single_pulse", int'(done), 0);
    check_eq("busy_idle", int'(busy), 0);
    out_ready = 1'b1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_busy"}, int'(busy), 0);
    check_eq({pfx, "_done"}, int'(done), 0);
    check_eq({pfx, "_err"}, int'(err), 0);
    check_eq({pfx, "_start_rom"}, int'(start_rom), 0);
    check_eq({pfx, "_rom_addr"}, int'(rom_addr), 0);
    check_eq({pfx, "_out_valid"}, int'(out_valid), 0);
    check_eq({pfx, "_out_data"}, int'(out_data), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Full burst, full rate.
    drive_start(0, 8);
    observe(4'b1111, 1'b0);
    post_checks(1'b1);

    // Backpressure pattern 1,0,0,1.
    drive_start(2, 4);
    observe(4'b1001, 1'b0);
    post_checks(1'b0);

    // Past the end of the ROM: wraps or is rejected.
    drive_start(6, 4);
    observe(4'b1111, 1'b0);
    post_checks(1'b1);

    // Zero length, with a second start while busy.
    drive_start(5, 0);
    observe(4'b1111, 1'b1);
    post_checks(1'b1);
    for (int i = 0; i < 3; i++) begin
      check_eq("second_start_ignored", int'(busy || start_rom), 0);
      @(posedge clk); #1;
    end

    // Reset with three words queued under backpressure.
    drive_start(0, 8);
    out_ready = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    rst = 1'b0;
    out_ready = 1'b1;
    drive_start(1, 1);
    observe(4'b1111, 1'b0);
    post_checks(1'b1);

    // Oversized length clamps to DEPTH.
    drive_start(0, 15);
    observe(4'b1111, 1'b0);
    post_checks(1'b1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
